cpu_seq_ctrl: RTL

// - Parametrised fetch/decode/execute sequencer for the SAP CPU; drives datapath enables (PC, IR, RAM, register file, ALU, OUT).
// - Generalises the two-FSM control to one FSM with N registers, a RAM ready handshake, single-step/halt debug and illegal-opcode trap.
// - Sits between the IR and the datapath; all state advances only on SLOW_CLOCK_STRB.

---
 rtl/cpu_seq_pkg.sv | 53 +++++
 rtl/cpu_seq_ctrl_if.sv | 49 ++++
 rtl/cpu_branch_eval.sv | 39 +++
 rtl/cpu_seq_ctrl.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/cpu_seq_pkg.sv
// Shared types and encodings for the SAP CPU fetch/decode/execute sequencer.
// The opcode CLASS, branch-condition codes and flag positions live here.
package cpu_seq_pkg;

  typedef enum logic [2:0] {
    S_FADDR = 3'd0,
    S_FDATA = 3'd1,
    S_EX0   = 3'd2,
    S_EX1   = 3'd3,
    S_HALT  = 3'd4
  } state_e;

  localparam logic [3:0] CLASS_LDR    = 4'h0;
  localparam logic [3:0] CLASS_STR    = 4'h1;
  localparam logic [3:0] CLASS_MOV    = 4'h2;
  localparam logic [3:0] CLASS_ALU_LO = 4'h4;
  localparam logic [3:0] CLASS_ALU_HI = 4'h9;
  localparam logic [3:0] CLASS_BCC    = 4'hE;
  localparam logic [3:0] CLASS_OUT    = 4'hF;

  localparam logic [3:0] COND_AL = 4'h0;
  localparam logic [3:0] COND_EQ = 4'h1;
  localparam logic [3:0] COND_NE = 4'h2;
  localparam logic [3:0] COND_HS = 4'h3;
  localparam logic [3:0] COND_LO = 4'h4;
  localparam logic [3:0] COND_MI = 4'h5;
  localparam logic [3:0] COND_PL = 4'h6;
  localparam logic [3:0] COND_VS = 4'h7;
  localparam logic [3:0] COND_VC = 4'h8;
  localparam logic [3:0] COND_HI = 4'h9;
  localparam logic [3:0] COND_LS = 4'hA;
  localparam logic [3:0] COND_GE = 4'hB;
  localparam logic [3:0] COND_LT = 4'hC;
  localparam logic [3:0] COND_GT = 4'hD;
  localparam logic [3:0] COND_LE = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  // condition_flags is packed {N,Z,C,V}
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  function automatic logic class_is_alu(input logic [3:0] c);
    return (c >= CLASS_ALU_LO) && (c <= CLASS_ALU_HI);
  endfunction

  function automatic logic class_is_legal(input logic [3:0] c);
    return (c == CLASS_LDR) || (c == CLASS_STR) || (c == CLASS_MOV) ||
           class_is_alu(c) || (c == CLASS_BCC) || (c == CLASS_OUT);
  endfunction

endpackage

// File: rtl/cpu_seq_ctrl_if.sv
// Sequencer <-> IR/datapath bundle. The master side is the sequencer,
// the slave side is the datapath/IR/debug logic that feeds it.
interface cpu_seq_ctrl_if #(
  parameter int NUM_REGS = 4
) ();
  localparam int REG_SEL_W = $clog2(NUM_REGS);
  localparam int INSTR_W   = 4 + 3 * REG_SEL_W;

  logic                SLOW_CLOCK_STRB;
  logic [INSTR_W-1:0]  FULL_OPCODE;
  logic [3:0]          condition_flags;
  logic                mem_ready;
  logic                HALT;
  logic                step_mode;
  logic                step_req;

  logic                pc_out;
  logic                pc_count;
  logic                ir_in;
  logic                ir_out;
  logic                ram_out;
  logic                ram_wr;
  logic                out_in;
  logic                alu_en;
  logic                branch;
  logic [NUM_REGS-1:0] reg_in;
  logic [NUM_REGS-1:0] reg_out;
  logic [NUM_REGS-1:0] reg_mov;
  logic [7:0]          alu_sel;
  logic                halted;
  logic                illegal_op;
  logic                instr_retired;

  modport master (
    input  SLOW_CLOCK_STRB, FULL_OPCODE, condition_flags, mem_ready,
           HALT, step_mode, step_req,
    output pc_out, pc_count, ir_in, ir_out, ram_out, ram_wr, out_in,
           alu_en, branch, reg_in, reg_out, reg_mov, alu_sel, halted,
           illegal_op, instr_retired
  );

  modport slave (
    output SLOW_CLOCK_STRB, FULL_OPCODE, condition_flags, mem_ready,
           HALT, step_mode, step_req,
    input  pc_out, pc_count, ir_in, ir_out, ram_out, ram_wr, out_in,
           alu_en, branch, reg_in, reg_out, reg_mov, alu_sel, halted,
           illegal_op, instr_retired
  );
endinterface

// File: rtl/cpu_branch_eval.sv
// ARM-style condition evaluation against the {N,Z,C,V} flags.
// Code 0 is always-taken and code F is never-taken.
module cpu_branch_eval
  import cpu_seq_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] flags_i,
  output logic       take_o
);
  logic n, z, c, v;

  assign n = flags_i[FLAG_N];
  assign z = flags_i[FLAG_Z];
  assign c = flags_i[FLAG_C];
  assign v = flags_i[FLAG_V];

  always_comb begin
    take_o = 1'b0;
    case (cond_i)
      COND_AL: take_o = 1'b1;
      COND_EQ: take_o = z;
      COND_NE: take_o = !z;
      COND_HS: take_o = c;
      COND_LO: take_o = !c;
      COND_MI: take_o = n;
      COND_PL: take_o = !n;
      COND_VS: take_o = v;
      COND_VC: take_o = !v;
      COND_HI: take_o = c && !z;
      COND_LS: take_o = !c || z;
      COND_GE: take_o = (n == v);
      COND_LT: take_o = (n != v);
      COND_GT: take_o = !z && (n == v);
      COND_LE: take_o = z || (n != v);
      COND_NV: take_o = 1'b0;
      default: take_o = 1'b0;
    endcase
  end
endmodule

// File: rtl/cpu_seq_ctrl.sv
// Fetch/decode/execute sequencer for the SAP CPU with N registers, RAM ready
// handshake, halt/single-step debug and an illegal-opcode trap.
module cpu_seq_ctrl #(
  parameter int NUM_REGS = 4
) (
  input  logic           CLK,
  input  logic           ARST_L,
  cpu_seq_ctrl_if.master bus
);
  import cpu_seq_pkg::*;

  localparam int REG_SEL_W = $clog2(NUM_REGS);
  localparam int INSTR_W   = 4 + 3 * REG_SEL_W;

  state_e               state_q, state_d;
  logic                 halt_meta_q, halt_sync_q;
  logic                 step_pend_q, step_pend_d;
  logic                 illegal_q, illegal_d;
  logic                 retire;

  logic [3:0]           cls;
  logic [REG_SEL_W-1:0] ra, rb, rd;
  logic [2*REG_SEL_W-1:0] rab;
  logic                 take;
  logic                 is_mem;

  assign cls    = bus.FULL_OPCODE[INSTR_W-1 -: 4];
  assign ra     = bus.FULL_OPCODE[3*REG_SEL_W-1 -: REG_SEL_W];
  assign rb     = bus.FULL_OPCODE[2*REG_SEL_W-1 -: REG_SEL_W];
  assign rd     = bus.FULL_OPCODE[REG_SEL_W-1:0];
  assign rab    = {ra, rb};
  assign is_mem = (cls == CLASS_LDR) || (cls == CLASS_STR);

  cpu_branch_eval u_branch (
    .cond_i  (rab[3:0]),
    .flags_i (bus.condition_flags),
    .take_o  (take)
  );

  always_ff @(posedge CLK or negedge ARST_L) begin
    if (!ARST_L) begin
      state_q     <= S_FADDR;
      halt_meta_q <= 1'b0;
      halt_sync_q <= 1'b0;
      step_pend_q <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      halt_meta_q <= bus.HALT;
      halt_sync_q <= halt_meta_q;
      step_pend_q <= step_pend_d;
      illegal_q   <= illegal_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    illegal_d   = illegal_q;
    retire      = 1'b0;
    step_pend_d = step_pend_q || (bus.step_req && (state_q == S_HALT));
    if (bus.SLOW_CLOCK_STRB) begin
      unique case (state_q)
        S_FADDR: state_d = S_FDATA;
        S_FDATA: if (bus.mem_ready) state_d = S_EX0;
        S_EX0: begin
          if (!class_is_legal(cls)) begin
            illegal_d = 1'b1;
            retire    = 1'b1;
          end else if (is_mem) begin
            state_d = S_EX1;
          end else begin
            retire = 1'b1;
          end
        end
        S_EX1: if (bus.mem_ready) retire = 1'b1;
        // An illegal-opcode trap parks the sequencer until reset
        S_HALT: begin
          if (!illegal_q &&
              ((!halt_sync_q && !bus.step_mode) || step_pend_d)) begin
            state_d     = S_FADDR;
            step_pend_d = 1'b0;
          end
        end
        default: state_d = S_FADDR;
      endcase
    end
    if (retire)
      state_d = (illegal_d || halt_sync_q || bus.step_mode) ? S_HALT : S_FADDR;
  end

  always_comb begin
    bus.pc_out   = 1'b0;
    bus.pc_count = 1'b0;
    bus.ir_in    = 1'b0;
    bus.ir_out   = 1'b0;
    bus.ram_out  = 1'b0;
    bus.ram_wr   = 1'b0;
    bus.out_in   = 1'b0;
    bus.alu_en   = 1'b0;
    bus.branch   = 1'b0;
    bus.reg_in   = '0;
    bus.reg_out  = '0;
    bus.reg_mov  = '0;
    unique case (state_q)
      S_FADDR: bus.pc_out = 1'b1;
      S_FDATA: begin
        bus.ram_out  = 1'b1;
        bus.ir_in    = 1'b1;
        bus.pc_count = 1'b1;
      end
      S_EX0: begin
        if (is_mem) begin
          bus.reg_out[ra] = 1'b1;
        end else if (cls == CLASS_MOV) begin
          bus.ir_out      = 1'b1;
          bus.reg_mov[rd] = 1'b1;
        end else if (class_is_alu(cls)) begin
          bus.alu_en     = 1'b1;
          bus.reg_in[rd] = 1'b1;
        end else if (cls == CLASS_OUT) begin
          bus.reg_out[ra] = 1'b1;
          bus.out_in      = 1'b1;
        end else if (cls == CLASS_BCC) begin
          bus.branch = take;
          bus.ir_out = 1'b1;
        end
      end
      S_EX1: begin
        if (cls == CLASS_LDR) begin
          bus.ram_out    = 1'b1;
          bus.reg_in[rd] = 1'b1;
        end else if (cls == CLASS_STR) begin
          bus.ram_wr      = 1'b1;
          bus.reg_out[rb] = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign bus.alu_sel       = {cls, rab[3:0]};
  assign bus.halted        = (state_q == S_HALT);
  assign bus.illegal_op    = illegal_q;
  assign bus.instr_retired = retire;

endmodule
